pe_block_fetcher: RTL and testbench
===================================

Name: pe_block_fetcher

Overview:
Processor-side counterpart of the main control unit's index scatter. One instance sits in each processing element. It accepts a (row, column) block-index pair over the ready/received handshake and requests the shared memory grant. It then fetches the addressed A block and B block into the PE's local operand buffer. Once the PE's compute core finishes, it reports result-ready back to the control unit.

Parameters:
index_width, 8, width of row/column block indexes
greek_size, 8, width of each dimension field in the config word
memory_size_log, 10, memory address width
block_size, 2, block edge length; block_words = block_size*block_size
buffer_addr_width, 4, local buffer address width; must satisfy 2*block_words <= 2**buffer_addr_width

Ports:
i_Clock  in  1  system clock, rising edge
i_Reset  in  1  synchronous, active-high reset
i_Indexes_Ready  in  1  this PE's bit of the control unit's one-hot index-ready vector (level)
i_Row_Index  in  index_width  A block index, valid while i_Indexes_Ready=1
i_Column_Index  in  index_width  B block index, valid while i_Indexes_Ready=1
i_Config  in  32  config word; [7:0] lambda, [15:8] gamma, [23:16] mu
o_Indexes_Received  out  1  one-cycle pulse acknowledging the index pair
o_Grant_Request  out  1  memory bus request (level)
i_Grant  in  1  memory bus grant (level)
o_Memory_Address  out  memory_size_log  read address (registered)
i_Memory_Data  in  32  read data; 1-cycle latency
o_Buffer_Write  out  1  local buffer write strobe
o_Buffer_Address  out  buffer_addr_width  local buffer write address
o_Buffer_Data  out  32  local buffer write data
i_Compute_Done  in  1  compute core finished (one-cycle pulse)
o_Start_Compute  out  1  one-cycle pulse when operands are loaded
o_Result_Ready  out  1  result available (level)
o_Busy  out  1  high in every state except S_IDLE and S_DONE

Behaviour:
- Reset: all outputs 0; state S_IDLE; latched indexes, counters and address 0.
- Memory layout: config at address 0, status at 1.
  - A block r sits at 2 + r*block_words.
  - B block c sits at 2 + gamma*block_words + c*block_words.
  - Address arithmetic is done at memory_size_log width, wrapping modulo 2**memory_size_log; no overflow flag.
- States: S_IDLE, S_REQUEST, S_FETCH, S_DRAIN, S_COMPUTE, S_DONE.
- S_IDLE / S_DONE, when i_Indexes_Ready=1:
  - Latch the indexes and compute both base addresses.
  - Pulse o_Indexes_Received for exactly one cycle.
  - Set o_Grant_Request=1, clear o_Result_Ready, go to S_REQUEST.
  - o_Indexes_Received is never asserted twice for one acceptance. While the PE is busy, i_Indexes_Ready is ignored.
- S_REQUEST: on i_Grant=1, drive o_Memory_Address = A base, clear word counter (0..2*block_words-1), go to S_FETCH.
- S_FETCH:
  - Each cycle with i_Grant=1, issue the next address. Words 0..block_words-1 come from A; the rest come from B (address jumps to B base at word block_words).
  - Data for the address issued in cycle n is captured at the end of cycle n+1. The capture drives o_Buffer_Write=1, o_Buffer_Address = word index and o_Buffer_Data = i_Memory_Data.
  - After the last address is issued, go to S_DRAIN.
- Grant loss mid-fetch (i_Grant=0): stop issuing and hold the address. The in-flight word from the previous cycle is still captured. o_Grant_Request stays 1. Issue resumes when i_Grant returns, with no word skipped or duplicated.
- S_DRAIN: capture the final word, drop o_Grant_Request, pulse o_Start_Compute, go to S_COMPUTE. Latency from grant to o_Start_Compute is 2*block_words+1 cycles with uninterrupted grant.
- S_COMPUTE: on i_Compute_Done, set o_Result_Ready=1 and go to S_DONE.
- S_DONE:
  - o_Result_Ready holds until the next index pair is accepted.
  - Simultaneous i_Indexes_Ready in S_DONE: acceptance wins and o_Result_Ready falls in that same registered update.
- i_Compute_Done outside S_COMPUTE is ignored.
- Reset mid-operation: immediate return to S_IDLE with all outputs 0, including dropping o_Grant_Request. No buffer write occurs in the reset cycle.
- Unreachable state encodings go to S_IDLE.

Test Plan:
1. Basic fetch (block_size=2, gamma=3, row=1, col=2, uninterrupted grant):
   - One o_Indexes_Received pulse.
   - Addresses 6,7,8,9,22,23,24,25.
   - Buffer addresses 0..7 written with the matching memory contents.
   - o_Start_Compute exactly 9 cycles after the grant cycle.
2. Grant dropped for 3 cycles after the third address issued -> address held; word 2 is still written; resume at address 9; exactly 8 buffer writes total, no duplicates.
3. i_Indexes_Ready held high for 20 cycles during fetch -> only one o_Indexes_Received pulse; indexes unchanged.
4. i_Compute_Done pulse -> o_Result_Ready=1 next cycle, holding. New i_Indexes_Ready -> o_Indexes_Received pulse, o_Result_Ready=0, o_Grant_Request=1 in the same cycle.
5. i_Reset asserted at word 5 of the fetch -> next cycle state idle, o_Grant_Request=0, o_Buffer_Write=0. A subsequent handshake restarts from word 0.
6. Wrap-around (memory_size_log=5, gamma=3, row=7, col=7, block_size=2):
   - A addresses 30,31,0,1.
   - B addresses (2+12+28)=42 mod 32 = 10..13.

Source files
------------

// File: rtl/pe_block_fetcher.sv
// ---------------------------------------------------------------------------
// pe_block_fetcher
//
// Processing-element side of the block-index scatter. Accepts a (row, column)
// block-index pair from the control unit, requests the shared memory bus,
// streams the addressed A block followed by the addressed B block into the
// PE's local operand buffer, starts the compute core, and reports
// result-ready once the core signals completion.
//
// Memory layout: word 0 config, word 1 status, A blocks from word 2,
// B blocks after gamma A blocks. Address arithmetic wraps modulo
// 2**memory_size_log.
//
// Ports:
//   i_Clock, i_Reset         rising-edge clock, synchronous active-high reset
//   i_Indexes_Ready          index pair offered (level)
//   i_Row_Index              A block index
//   i_Column_Index           B block index
//   i_Config                 [7:0] lambda, [15:8] gamma, [23:16] mu
//   o_Indexes_Received       one-cycle acknowledge of the index pair
//   o_Grant_Request          memory bus request (level)
//   i_Grant                  memory bus grant (level)
//   o_Memory_Address         registered read address
//   i_Memory_Data            read data, one cycle after the address
//   o_Buffer_Write           local buffer write strobe
//   o_Buffer_Address         local buffer word index
//   o_Buffer_Data            local buffer write data
//   i_Compute_Done           compute core finished (pulse)
//   o_Start_Compute          one-cycle pulse, operands loaded
//   o_Result_Ready           result available (level)
//   o_Busy                   high outside S_IDLE and S_DONE
// ---------------------------------------------------------------------------
module pe_block_fetcher #(
  parameter int index_width       = 8,
  parameter int greek_size        = 8,
  parameter int memory_size_log   = 10,
  parameter int block_size        = 2,
  parameter int buffer_addr_width = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Indexes_Ready,
  input  logic [index_width-1:0]       i_Row_Index,
  input  logic [index_width-1:0]       i_Column_Index,
  input  logic [31:0]                  i_Config,
  output logic                         o_Indexes_Received,
  output logic                         o_Grant_Request,
  input  logic                         i_Grant,
  output logic [memory_size_log-1:0]   o_Memory_Address,
  input  logic [31:0]                  i_Memory_Data,
  output logic                         o_Buffer_Write,
  output logic [buffer_addr_width-1:0] o_Buffer_Address,
  output logic [31:0]                  o_Buffer_Data,
  input  logic                         i_Compute_Done,
  output logic                         o_Start_Compute,
  output logic                         o_Result_Ready,
  output logic                         o_Busy
);

  localparam int block_words = block_size * block_size;
  localparam int total_words = 2 * block_words;

  localparam logic [buffer_addr_width-1:0] last_word    = buffer_addr_width'(total_words - 1);
  localparam logic [buffer_addr_width-1:0] b_first_word = buffer_addr_width'(block_words);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_FETCH   = 3'd2,
    S_DRAIN   = 3'd3,
    S_COMPUTE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                       state;
  logic [index_width-1:0]       row_index;
  logic [index_width-1:0]       column_index;
  logic [greek_size-1:0]        gamma;
  logic [memory_size_log-1:0]   a_base;
  logic [memory_size_log-1:0]   b_base;

  // word_p0: index of the word whose address is on o_Memory_Address.
  // vld_p1/word_p1: that word was granted last cycle, its data is on the bus now.
  logic [buffer_addr_width-1:0] word_p0;
  logic                         vld_p1;
  logic [buffer_addr_width-1:0] word_p1;

  // Only gamma is consumed from the config word.
  logic unused_config;
  assign unused_config = ^{i_Config[31:2*greek_size], i_Config[greek_size-1:0]};

  // Address of word 0 of block number (first_block + idx); the 32-bit sum is
  // truncated so the result wraps modulo 2**memory_size_log.
  function automatic logic [memory_size_log-1:0] block_addr(
    input logic [31:0] first_block,
    input logic [31:0] idx
  );
    logic [31:0] full;
    full = 32'd2 + (first_block + idx) * 32'(block_words);
    return full[memory_size_log-1:0];
  endfunction

  assign a_base = block_addr(32'd0, 32'(row_index));
  assign b_base = block_addr(32'(gamma), 32'(column_index));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state              <= S_IDLE;
      row_index          <= '0;
      column_index       <= '0;
      gamma              <= '0;
      word_p0            <= '0;
      vld_p1             <= 1'b0;
      word_p1            <= '0;
      o_Memory_Address   <= '0;
      o_Indexes_Received <= 1'b0;
      o_Grant_Request    <= 1'b0;
      o_Start_Compute    <= 1'b0;
      o_Result_Ready     <= 1'b0;
    end else begin
      o_Indexes_Received <= 1'b0;
      o_Start_Compute    <= 1'b0;
      vld_p1             <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          // Acceptance takes priority over holding a finished result.
          if (i_Indexes_Ready) begin
            row_index          <= i_Row_Index;
            column_index       <= i_Column_Index;
            gamma              <= i_Config[2*greek_size-1:greek_size];
            o_Indexes_Received <= 1'b1;
            o_Grant_Request    <= 1'b1;
            o_Result_Ready     <= 1'b0;
            state              <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (i_Grant) begin
            o_Memory_Address <= a_base;
            word_p0          <= '0;
            state            <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Stage p0 -> p1: a granted address becomes an in-flight word.
          // Without grant the address is held and re-offered next cycle.
          if (i_Grant) begin
            vld_p1  <= 1'b1;
            word_p1 <= word_p0;
            if (word_p0 == last_word) begin
              o_Grant_Request <= 1'b0;
              o_Start_Compute <= 1'b1;
              state           <= S_DRAIN;
            end else begin
              word_p0 <= word_p0 + buffer_addr_width'(1);
              if (word_p0 + buffer_addr_width'(1) == b_first_word) begin
                o_Memory_Address <= b_base;
              end else begin
                o_Memory_Address <= o_Memory_Address + memory_size_log'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          // The last word is written this cycle from the p1 stage.
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (i_Compute_Done) begin
            o_Result_Ready <= 1'b1;
            state          <= S_DONE;
          end
        end
        default: begin
          o_Grant_Request <= 1'b0;
          o_Result_Ready  <= 1'b0;
          state           <= S_IDLE;
        end
      endcase
    end
  end

  // Stage p1 -> buffer: capture the returning word. Suppressed while reset is
  // asserted so an aborted fetch never lands a word.
  assign o_Buffer_Write   = vld_p1 & ~i_Reset;
  assign o_Buffer_Address = o_Buffer_Write ? word_p1 : '0;
  assign o_Buffer_Data    = o_Buffer_Write ? i_Memory_Data : '0;

  assign o_Busy = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_pe_block_fetcher.sv
module tb_pe_block_fetcher;

  localparam int BW    = 4;
  localparam int TOTAL = 8;

  logic        clk;
  logic        i_Reset;
  logic        i_Indexes_Ready;
  logic [7:0]  i_Row_Index;
  logic [7:0]  i_Column_Index;
  logic [31:0] i_Config;
  logic        i_Grant;
  logic        i_Compute_Done;
  logic [31:0] mem_data;
  logic [31:0] mem_data_w;

  logic        o_Indexes_Received, o_Grant_Request, o_Buffer_Write;
  logic [9:0]  o_Memory_Address;
  logic [3:0]  o_Buffer_Address;
  logic [31:0] o_Buffer_Data;
  logic        o_Start_Compute, o_Result_Ready, o_Busy;

  logic        w_Indexes_Received, w_Grant_Request, w_Buffer_Write;
  logic [4:0]  w_Memory_Address;
  logic [3:0]  w_Buffer_Address;
  logic [31:0] w_Buffer_Data;
  logic        w_Start_Compute, w_Result_Ready, w_Busy;

  pe_block_fetcher #(.memory_size_log(10)) dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Indexes_Ready(i_Indexes_Ready),
    .i_Row_Index(i_Row_Index), .i_Column_Index(i_Column_Index), .i_Config(i_Config),
    .o_Indexes_Received(o_Indexes_Received), .o_Grant_Request(o_Grant_Request),
    .i_Grant(i_Grant), .o_Memory_Address(o_Memory_Address), .i_Memory_Data(mem_data),
    .o_Buffer_Write(o_Buffer_Write), .o_Buffer_Address(o_Buffer_Address),
    .o_Buffer_Data(o_Buffer_Data), .i_Compute_Done(i_Compute_Done),
    .o_Start_Compute(o_Start_Compute), .o_Result_Ready(o_Result_Ready), .o_Busy(o_Busy)
  );

  pe_block_fetcher #(.memory_size_log(5)) dut_w (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Indexes_Ready(i_Indexes_Ready),
    .i_Row_Index(i_Row_Index), .i_Column_Index(i_Column_Index), .i_Config(i_Config),
    .o_Indexes_Received(w_Indexes_Received), .o_Grant_Request(w_Grant_Request),
    .i_Grant(i_Grant), .o_Memory_Address(w_Memory_Address), .i_Memory_Data(mem_data_w),
    .o_Buffer_Write(w_Buffer_Write), .o_Buffer_Address(w_Buffer_Address),
    .o_Buffer_Data(w_Buffer_Data), .i_Compute_Done(i_Compute_Done),
    .o_Start_Compute(w_Start_Compute), .o_Result_Ready(w_Result_Ready), .o_Busy(w_Busy)
  );

  typedef struct {
    int          row;
    int          col;
    int          gam;
    int          delay;
    int          drop_after;
    int          drop_len;
    bit          hold;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] wa0;
    logic [31:0] wb0;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          rcv_count, start_count, start_cyc, g_cyc;
  bit          seen_g;
  logic [31:0] a_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] wi_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] wdw_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents are a fixed function of the address; the two memories differ.
  function automatic logic [31:0] memfn(input logic [31:0] addr, input logic [31:0] salt);
    return 32'h5EED_0000 ^ (addr * 32'h0001_0193) ^ (salt * 32'h7700_0000);
  endfunction

  always @(posedge clk) begin
    mem_data   <= memfn(32'(o_Memory_Address), 32'd0);
    mem_data_w <= memfn(32'(w_Memory_Address), 32'd1);
  end

  // Reference: word w of a fetch comes from the A block for w < BW and from
  // the B block otherwise, addresses taken modulo 2**msl.
  function automatic logic [31:0] model_addr(input int row, input int col, input int gam,
                                             input int w, input int msl);
    longint a;
    if (w < BW) a = 2 + longint'(row) * BW + w;
    else        a = 2 + longint'(gam) * BW + longint'(col) * BW + (w - BW);
    return 32'(a % (longint'(1) << msl));
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Observation of both instances at the falling edge.
  always @(negedge clk) begin
    if (o_Indexes_Received) rcv_count++;
    if (o_Start_Compute) begin
      start_count++;
      start_cyc = cyc;
    end
    if (o_Buffer_Write) begin
      wi_q.push_back(32'(o_Buffer_Address));
      wd_q.push_back(o_Buffer_Data);
    end
    if (w_Buffer_Write) wdw_q.push_back(w_Buffer_Data);
    if (o_Grant_Request && i_Grant) begin
      if (!seen_g) begin
        seen_g = 1'b1;
        g_cyc  = cyc;
      end else begin
        a_q.push_back(32'(o_Memory_Address));
        aw_q.push_back(32'(w_Memory_Address));
      end
    end else if (!o_Grant_Request) begin
      seen_g = 1'b0;
    end
  end

  task automatic run_txn(input int id, input vec_t v, input bit spurious, input int done_wait);
    int j, gcount, dropped;
    logic [31:0] ea, ew;
    a_q.delete(); aw_q.delete(); wi_q.delete(); wd_q.delete(); wdw_q.delete();
    rcv_count = 0; start_count = 0; start_cyc = 0; g_cyc = 0;
    i_Indexes_Ready = 1'b1;
    i_Row_Index     = 8'(v.row);
    i_Column_Index  = 8'(v.col);
    i_Config        = {8'($urandom), 8'($urandom), 8'(v.gam), 8'($urandom)};
    @(posedge clk); #1;
    // Index inputs are only meaningful during the offer; scramble them now.
    i_Row_Index    = ~8'(v.row);
    i_Column_Index = 8'($urandom);
    i_Config       = $urandom;
    chk($sformatf("v%0d ack_pulse", id), 32'(o_Indexes_Received), 32'd1);
    chk($sformatf("v%0d ack_req", id), 32'(o_Grant_Request), 32'd1);
    chk($sformatf("v%0d ack_result_clr", id), 32'(o_Result_Ready), 32'd0);
    chk($sformatf("v%0d ack_busy", id), 32'(o_Busy), 32'd1);
    j = 0; gcount = 0; dropped = 0;
    while (start_count == 0 && j < 80) begin
      i_Indexes_Ready = v.hold && (j < 20);
      i_Compute_Done  = spurious && (j == 3);
      if (j < v.delay) begin
        i_Grant = 1'b0;
      end else if (gcount == 1 + v.drop_after && dropped < v.drop_len) begin
        i_Grant = 1'b0;
        dropped++;
      end else begin
        i_Grant = 1'b1;
        gcount++;
      end
      @(posedge clk); #1;
      j++;
    end
    i_Grant = 1'b0;
    i_Compute_Done = 1'b0;
    chk($sformatf("v%0d start_seen", id), 32'(start_count), 32'd1);
    chk($sformatf("v%0d compute_busy", id), 32'(o_Busy), 32'd1);
    chk($sformatf("v%0d compute_req_low", id), 32'(o_Grant_Request), 32'd0);
    chk($sformatf("v%0d start_one_cycle", id), 32'(o_Start_Compute), 32'd0);
    chk($sformatf("v%0d latency", id), 32'(start_cyc - g_cyc), 32'(v.lat));
    while (v.hold && j < 20) begin
      @(posedge clk); #1;
      j++;
    end
    i_Indexes_Ready = 1'b0;
    chk($sformatf("v%0d ack_count", id), 32'(rcv_count), 32'd1);
    chk($sformatf("v%0d addr_count", id), 32'(a_q.size()), 32'(TOTAL));
    chk($sformatf("v%0d write_count", id), 32'(wi_q.size()), 32'(TOTAL));
    chk($sformatf("v%0d write_count_w", id), 32'(wdw_q.size()), 32'(TOTAL));
    for (int i = 0; i < TOTAL; i++) begin
      ea = model_addr(v.row, v.col, v.gam, i, 10);
      ew = model_addr(v.row, v.col, v.gam, i, 5);
      chk($sformatf("v%0d addr%0d", id, i), qget(a_q, i), ea);
      chk($sformatf("v%0d addr_w%0d", id, i), qget(aw_q, i), ew);
      chk($sformatf("v%0d wr_idx%0d", id, i), qget(wi_q, i), 32'(i));
      chk($sformatf("v%0d wr_data%0d", id, i), qget(wd_q, i), memfn(ea, 32'd0));
      chk($sformatf("v%0d wr_data_w%0d", id, i), qget(wdw_q, i), memfn(ew, 32'd1));
    end
    chk($sformatf("v%0d a_first", id), qget(a_q, 0), v.a0);
    chk($sformatf("v%0d b_first", id), qget(a_q, BW), v.b0);
    chk($sformatf("v%0d a_first_w", id), qget(aw_q, 0), v.wa0);
    chk($sformatf("v%0d b_first_w", id), qget(aw_q, BW), v.wb0);
    for (int k = 0; k < done_wait; k++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d result_before_done", id), 32'(o_Result_Ready), 32'd0);
    i_Compute_Done = 1'b1;
    @(posedge clk); #1;
    i_Compute_Done = 1'b0;
    chk($sformatf("v%0d result_ready", id), 32'(o_Result_Ready), 32'd1);
    chk($sformatf("v%0d done_not_busy", id), 32'(o_Busy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk($sformatf("v%0d result_hold", id), 32'(o_Result_Ready), 32'd1);
  endtask

  task automatic reset_mid_fetch();
    i_Indexes_Ready = 1'b1;
    i_Row_Index     = 8'd3;
    i_Column_Index  = 8'd1;
    i_Config        = 32'h0000_0500;
    @(posedge clk); #1;
    i_Indexes_Ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_Grant = 1'b1;
      @(posedge clk); #1;
    end
    // Word 5 = B word 1: 2 + 5*4 + 1*4 + 1 = 27.
    chk("rst pre_addr", 32'(o_Memory_Address), 32'd27);
    i_Reset = 1'b1;
    @(negedge clk);
    chk("rst cycle_no_write", 32'(o_Buffer_Write), 32'd0);
    @(posedge clk); #1;
    i_Reset = 1'b0;
    i_Grant = 1'b0;
    chk("rst req_low", 32'(o_Grant_Request), 32'd0);
    chk("rst no_write", 32'(o_Buffer_Write), 32'd0);
    chk("rst idle", 32'(o_Busy), 32'd0);
    chk("rst addr_zero", 32'(o_Memory_Address), 32'd0);
    chk("rst start_low", 32'(o_Start_Compute), 32'd0);
    chk("rst result_low", 32'(o_Result_Ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t rv;
    tbl[0] = '{1, 2, 3, 0, 0, 0, 1'b0, 32'd6,    32'd22,  32'd6,  32'd22, 9};
    tbl[1] = '{1, 2, 3, 2, 3, 3, 1'b0, 32'd6,    32'd22,  32'd6,  32'd22, 12};
    tbl[2] = '{1, 2, 3, 1, 0, 0, 1'b1, 32'd6,    32'd22,  32'd6,  32'd22, 9};
    tbl[3] = '{7, 7, 3, 0, 0, 0, 1'b0, 32'd30,   32'd42,  32'd30, 32'd10, 9};
    tbl[4] = '{255, 100, 200, 0, 0, 0, 1'b0, 32'd1022, 32'd178, 32'd30, 32'd18, 9};
    tbl[5] = '{0, 0, 0, 0, 0, 2, 1'b0, 32'd2,    32'd2,   32'd2,  32'd2,  11};

    i_Reset = 1'b1; i_Indexes_Ready = 1'b0; i_Row_Index = '0; i_Column_Index = '0;
    i_Config = '0; i_Grant = 1'b0; i_Compute_Done = 1'b0;
    seen_g = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(o_Indexes_Received), 32'd0);
    chk("reset req", 32'(o_Grant_Request), 32'd0);
    chk("reset addr", 32'(o_Memory_Address), 32'd0);
    chk("reset write", 32'(o_Buffer_Write), 32'd0);
    chk("reset start", 32'(o_Start_Compute), 32'd0);
    chk("reset result", 32'(o_Result_Ready), 32'd0);
    chk("reset busy", 32'(o_Busy), 32'd0);
    i_Reset = 1'b0;

    // A completion pulse while idle must not raise result-ready.
    i_Compute_Done = 1'b1;
    @(posedge clk); #1;
    i_Compute_Done = 1'b0;
    @(posedge clk); #1;
    chk("idle done_ignored", 32'(o_Result_Ready), 32'd0);
    chk("idle still_idle", 32'(o_Busy), 32'd0);

    for (int t = 0; t < 6; t++) run_txn(t, tbl[t], 1'b0, t % 3);

    reset_mid_fetch();
    run_txn(10, tbl[0], 1'b0, 1);

    for (int r = 0; r < 16; r++) begin
      rv.row        = int'($urandom_range(0, 255));
      rv.col        = int'($urandom_range(0, 255));
      rv.gam        = int'($urandom_range(0, 255));
      rv.delay      = int'($urandom_range(0, 3));
      rv.drop_after = int'($urandom_range(0, 7));
      rv.drop_len   = int'($urandom_range(0, 4));
      rv.hold       = ($urandom_range(0, 3) == 0);
      rv.a0         = model_addr(rv.row, rv.col, rv.gam, 0, 10);
      rv.b0         = model_addr(rv.row, rv.col, rv.gam, BW, 10);
      rv.wa0        = model_addr(rv.row, rv.col, rv.gam, 0, 5);
      rv.wb0        = model_addr(rv.row, rv.col, rv.gam, BW, 5);
      rv.lat        = 9 + rv.drop_len;
      run_txn(100 + r, rv, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
